// File: rtl/cv32e40p_ft_breakage_monitor.sv
// Breakage monitor for the triplicated IF-stage submodules.
// Each submodule owns a saturating up/down error counter; crossing the
// threshold sets a sticky broken flag and queues a one-shot event for the
// controller. A registered read port exposes any counter value.
module cv32e40p_ft_breakage_monitor #(
  parameter int unsigned N_SUB              = 6,
  parameter int unsigned COUNT_BIT          = 8,
  parameter int unsigned INC_DEC_BIT        = 2,
  parameter logic [INC_DEC_BIT-1:0] INCREMENT = INC_DEC_BIT'(1),
  parameter logic [INC_DEC_BIT-1:0] DECREMENT = INC_DEC_BIT'(1),
  parameter int unsigned BREAKING_THRESHOLD = 3,
  localparam int unsigned IDX_W             = $clog2(N_SUB)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SUB-1:0]     err_i,
  input  logic                 clear_i,
  output logic [N_SUB-1:0]     broken_o,
  output logic                 any_broken_o,
  output logic                 evt_valid_o,
  output logic [IDX_W-1:0]     evt_idx_o,
  input  logic                 evt_ready_i,
  input  logic                 rd_en_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic                 rd_valid_o,
  output logic [COUNT_BIT-1:0] rd_count_o,
  output logic                 rd_err_o
);

  // One extra bit of headroom so both overflow and underflow show up in the MSB.
  localparam int unsigned SUM_W = COUNT_BIT + 1;
  localparam logic [SUM_W-1:0]     INC_EXT = SUM_W'(INCREMENT);
  localparam logic [SUM_W-1:0]     DEC_EXT = SUM_W'(DECREMENT);
  localparam logic [COUNT_BIT-1:0] CNT_MAX = '1;
  localparam logic [COUNT_BIT-1:0] THRESH  = COUNT_BIT'(BREAKING_THRESHOLD);

  typedef enum logic {ST_IDLE, ST_REPORT} state_e;

  logic [COUNT_BIT-1:0] cnt_q [N_SUB];
  logic [COUNT_BIT-1:0] cnt_d [N_SUB];
  logic [SUM_W-1:0]     upd   [N_SUB];
  logic [N_SUB-1:0]     broken_q, broken_d;
  logic [N_SUB-1:0]     pending_q, pending_d;
  logic [N_SUB-1:0]     newly_broken;
  state_e               state_q;
  logic                 evt_valid_q;
  logic [IDX_W-1:0]     evt_idx_q;
  logic [IDX_W-1:0]     first_idx;
  logic                 evt_accept;
  logic                 rd_valid_q, rd_err_q;
  logic [COUNT_BIT-1:0] rd_count_q;
  logic [COUNT_BIT-1:0] rd_sel;
  logic                 rd_oob;

  assign evt_accept = evt_valid_q & evt_ready_i;
  assign rd_oob     = 32'(rd_idx_i) >= N_SUB;

  // Next counter values (clamped) and the resulting sticky broken flags.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    broken_d = broken_q;
    for (int k = 0; k < int'(N_SUB); k++) begin
      upd[k] = err_i[k] ? ({1'b0, cnt_q[k]} + INC_EXT) : ({1'b0, cnt_q[k]} - DEC_EXT);
      if (clear_i) begin
        cnt_d[k] = '0;
      end else if (upd[k][COUNT_BIT]) begin
        // MSB set: overflow when incrementing, borrow when decrementing.
        cnt_d[k] = err_i[k] ? CNT_MAX : '0;
      end else begin
        cnt_d[k] = upd[k][COUNT_BIT-1:0];
      end
      if (!clear_i && (cnt_d[k] >= THRESH)) broken_d[k] = 1'b1;
    end
    if (clear_i) broken_d = '0;
    newly_broken = broken_d & ~broken_q;
  end

  // Pending events: raised with the broken flag, dropped when accepted.
  always_comb begin
    pending_d = pending_q;
    if (evt_accept) pending_d[evt_idx_q] = 1'b0;
    pending_d = pending_d | newly_broken;
    if (clear_i) pending_d = '0;
  end

  // Lowest-index pending submodule wins arbitration.
  always_comb begin
    first_idx = '0;
    for (int k = int'(N_SUB) - 1; k >= 0; k--) begin
      if (pending_q[k]) first_idx = IDX_W'(k);
    end
  end

  // Read mux over the freshly updated counters; out-of-range selects nothing.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < int'(N_SUB); k++) begin
      if (rd_idx_i == IDX_W'(k)) rd_sel = cnt_d[k];
    end
  end

  // Counter, broken and pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      // NOTE: the counter array is architectural state, so each entry is explicitly reset rather than left to power-up.
      for (int k = 0; k < int'(N_SUB); k++) cnt_q[k] <= '0;
      broken_q  <= '0;
      pending_q <= '0;
    end else begin
      for (int k = 0; k < int'(N_SUB); k++) cnt_q[k] <= cnt_d[k];
      broken_q  <= broken_d;
      pending_q <= pending_d;
    end
  end

  // Event FSM with registered valid/index outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
    end else if (clear_i) begin
      state_q     <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            evt_idx_q   <= first_idx;
            evt_valid_q <= 1'b1;
            state_q     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (evt_accept) begin
            evt_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered read port, one response per request, suppressed by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      rd_err_q   <= 1'b0;
    end else if (clear_i) begin
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      rd_err_q   <= 1'b0;
    end else if (rd_en_i) begin
      rd_valid_q <= 1'b1;
      rd_count_q <= rd_oob ? '0 : rd_sel;
      rd_err_q   <= rd_oob;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign broken_o     = broken_q;
  assign any_broken_o = |broken_q;
  assign evt_valid_o  = evt_valid_q;
  assign evt_idx_o    = evt_idx_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_count_o   = rd_count_q;
  assign rd_err_o     = rd_err_q;

endmodule

// File: tb/tb_cv32e40p_ft_breakage_monitor.sv
// Scoreboard bench for the breakage monitor: a driver applies directed and
// random stimulus while stepping a behavioural model and queuing expectations;
// a monitor pops them whenever the DUT presents state, a read or an event.
module tb_cv32e40p_ft_breakage_monitor;

  localparam int N_SUB = 6;
  localparam int CMAX  = 255;
  localparam int THR   = 3;
  localparam int INC   = 1;
  localparam int DEC   = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] err_i;
  logic       clear_i;
  logic [5:0] broken_o;
  logic       any_broken_o;
  logic       evt_valid_o;
  logic [2:0] evt_idx_o;
  logic       evt_ready_i;
  logic       rd_en_i;
  logic [2:0] rd_idx_i;
  logic       rd_valid_o;
  logic [7:0] rd_count_o;
  logic       rd_err_o;

  cv32e40p_ft_breakage_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .err_i        (err_i),
    .clear_i      (clear_i),
    .broken_o     (broken_o),
    .any_broken_o (any_broken_o),
    .evt_valid_o  (evt_valid_o),
    .evt_idx_o    (evt_idx_o),
    .evt_ready_i  (evt_ready_i),
    .rd_en_i      (rd_en_i),
    .rd_idx_i     (rd_idx_i),
    .rd_valid_o   (rd_valid_o),
    .rd_count_o   (rd_count_o),
    .rd_err_o     (rd_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] brk;
    logic       valid;
    logic [2:0] idx;
    logic       rd;
  } cyc_exp_t;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
  } rd_exp_t;

  cyc_exp_t cyc_q[$];
  rd_exp_t  rd_q[$];
  int       evt_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int m_cnt  [N_SUB];
  bit m_brk  [N_SUB];
  bit m_pend [N_SUB];
  bit m_busy;
  int m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_SUB; k++) begin
      m_cnt[k]  = 0;
      m_brk[k]  = 1'b0;
      m_pend[k] = 1'b0;
    end
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  // Apply one cycle of inputs and predict what the following edge produces.
  task automatic step(input logic [5:0] err, input bit clr, input bit rdy, input bit ren, input int ridx);
    bit       old_pend [N_SUB];
    bit       newly    [N_SUB];
    int       lowest;
    cyc_exp_t c;
    rd_exp_t  r;
    @(negedge clk);
    err_i       = err;
    clear_i     = clr;
    evt_ready_i = rdy;
    rd_en_i     = ren;
    rd_idx_i    = 3'(ridx);
    if (clr) begin
      model_reset();
    end else begin
      old_pend = m_pend;
      for (int k = 0; k < N_SUB; k++) begin
        if (err[k]) m_cnt[k] = (m_cnt[k] + INC > CMAX) ? CMAX : m_cnt[k] + INC;
        else        m_cnt[k] = (m_cnt[k] - DEC < 0) ? 0 : m_cnt[k] - DEC;
        newly[k] = !m_brk[k] && (m_cnt[k] >= THR);
        if (newly[k]) m_brk[k] = 1'b1;
      end
      if (m_busy) begin
        if (rdy) begin
          m_pend[m_idx] = 1'b0;
          m_busy = 1'b0;
        end
      end else begin
        lowest = -1;
        for (int k = N_SUB - 1; k >= 0; k--) if (old_pend[k]) lowest = k;
        if (lowest >= 0) begin
          m_idx  = lowest;
          m_busy = 1'b1;
          evt_q.push_back(lowest);
        end
      end
      for (int k = 0; k < N_SUB; k++) if (newly[k]) m_pend[k] = 1'b1;
    end
    c.rd = ren && !clr;
    if (c.rd) begin
      r.err = (ridx >= N_SUB);
      r.cnt = (ridx < N_SUB) ? 8'(m_cnt[ridx]) : 8'd0;
      rd_q.push_back(r);
    end
    for (int k = 0; k < N_SUB; k++) c.brk[k] = m_brk[k];
    c.valid = m_busy;
    c.idx   = 3'(m_idx);
    cyc_q.push_back(c);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_broken"},     broken_o, 0);
    check({tag, "_any_broken"}, any_broken_o, 0);
    check({tag, "_evt_valid"},  evt_valid_o, 0);
    check({tag, "_evt_idx"},    evt_idx_o, 0);
    check({tag, "_rd_valid"},   rd_valid_o, 0);
    check({tag, "_rd_count"},   rd_count_o, 0);
    check({tag, "_rd_err"},     rd_err_o, 0);
  endtask

  // Asynchronous reset between edges; outputs must drop immediately.
  task automatic do_reset_async();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    cyc_q.delete();
    rd_q.delete();
    evt_q.delete();
    err_i = '0; clear_i = 1'b0; evt_ready_i = 1'b0; rd_en_i = 1'b0; rd_idx_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  initial begin
    bit       prev_valid;
    cyc_exp_t c;
    rd_exp_t  r;
    int       e;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("broken", broken_o, c.brk);
        check("any_broken", any_broken_o, |c.brk);
        check("evt_valid", evt_valid_o, c.valid);
        if (c.valid && evt_valid_o) check("evt_idx", evt_idx_o, c.idx);
        check("rd_valid", rd_valid_o, c.rd);
      end
      if (rd_valid_o) begin
        if (rd_q.size() == 0) begin
          check("rd_spurious", rd_valid_o, 0);
        end else begin
          r = rd_q.pop_front();
          check("rd_count", rd_count_o, r.cnt);
          check("rd_err", rd_err_o, r.err);
        end
      end
      if (evt_valid_o && !prev_valid) begin
        if (evt_q.size() == 0) begin
          check("evt_spurious", evt_valid_o, 0);
        end else begin
          e = evt_q.pop_front();
          check("evt_report_idx", evt_idx_o, e);
        end
      end
      prev_valid = evt_valid_o;
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver.
  initial begin
    int         bias;
    logic [5:0] e;
    rst_n = 1'b0;
    err_i = '0; clear_i = 1'b0; evt_ready_i = 1'b0; rd_en_i = 1'b0; rd_idx_i = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Threshold crossing on submodule 2, event held until accepted.
    for (int i = 0; i < 3; i++) step(6'b000100, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(6'b000000, 0, 0, 0, 0);
    step(6'b000000, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(6'b000000, 0, 0, 1, 2);

    // Decay without breaking, then break and decay to zero while staying broken.
    step(6'b000000, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++)  step(6'b000001, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++)  step(6'b000000, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++)  step(6'b000001, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(6'b000000, 0, 1, 1, 0);

    // Saturation on submodule 5.
    step(6'b000000, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(6'b100000, 0, 1, i >= 290, 5);
    for (int i = 0; i < 3; i++) step(6'b000000, 0, 1, 1, 5);

    // Simultaneous breaks: index priority, one IDLE gap between events.
    step(6'b000000, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(6'b100010, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(6'b000000, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(6'b000000, 0, 1, 0, 0);

    // Clear while reporting, with a read on the clear cycle.
    for (int i = 0; i < 3; i++) step(6'b001000, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(6'b000000, 0, 0, 0, 0);
    step(6'b000000, 1, 0, 1, 3);
    for (int i = 0; i < N_SUB; i++) step(6'b000000, 0, 1, 1, i);
    for (int i = 0; i < 4; i++) step(6'b000000, 0, 1, 0, 0);

    // Read edge cases: out-of-range indices and back-to-back reads.
    step(6'b000000, 0, 0, 1, 6);
    step(6'b000000, 0, 0, 1, 7);
    for (int i = 0; i < N_SUB; i++) step(6'($urandom_range(0, 63)), 0, 1, 1, i);

    // Asynchronous reset while an event and a read response are live.
    step(6'b000000, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(6'b010000, 0, 0, 1, 4);
    step(6'b000000, 0, 0, 1, 4);
    do_reset_async();

    // Randomized traffic with varying error density.
    for (int blk = 0; blk < 12; blk++) begin
      bias = int'($urandom_range(20, 70));
      for (int i = 0; i < 200; i++) begin
        for (int b = 0; b < N_SUB; b++) e[b] = ($urandom_range(0, 99) < bias);
        step(e, $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 40,
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
      end
      if (blk % 4 == 3) do_reset_async();
    end

    step(6'b000000, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("rd_queue_drained", rd_q.size(), 0);
    check("evt_queue_drained", evt_q.size(), 0);
    check("cyc_queue_drained", cyc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
